// File: rtl/hamming_tx.sv
// Hamming(7,4) encoder with a framed serial transmitter: start bit, c6..c0, stop bit.
// Optional build macro HAM_TX_FAULT_INJECT_EN adds fault_en/fault_pos to flip one codeword bit.
module hamming_tx #(
  parameter int BIT_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       data_valid,
`ifdef HAM_TX_FAULT_INJECT_EN
  input  logic       fault_en,
  input  logic [2:0] fault_pos,
`endif
  output logic       data_ready,
  output logic       ser_out,
  output logic       busy,
  output logic       word_done,
  output logic [6:0] cw_out,
  output logic [7:0] tx_count
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] TICK_LAST = 8'(BIT_TICKS - 1);

  state_t     state, state_next;
  logic [7:0] tick, tick_next;
  logic [2:0] bitc, bit_next;
  logic       ser_next;
  logic [6:0] cw_load;

  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

`ifdef HAM_TX_FAULT_INJECT_EN
  // Position 7 lies outside the codeword and deliberately yields an empty mask.
  function automatic logic [6:0] fault_mask(input logic en, input logic [2:0] pos);
    logic [7:0] onehot;
    onehot = 8'(1) << pos;
    return en ? onehot[6:0] : 7'd0;
  endfunction

  assign cw_load = encode(data_in) ^ fault_mask(fault_en, fault_pos);
`else
  assign cw_load = encode(data_in);
`endif

  assign data_ready = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);
  assign word_done  = (state == STOP) && (tick == TICK_LAST);

  // Next-state logic also computes the line level for the coming cycle so ser_out is a plain flop.
  always_comb begin
    state_next = state;
    tick_next  = tick;
    bit_next   = bitc;
    ser_next   = 1'b1;
    case (state)
      IDLE: begin
        if (data_valid) begin
          state_next = START;
          tick_next  = 8'd0;
          bit_next   = 3'd0;
          ser_next   = 1'b0;
        end
      end
      START: begin
        ser_next = 1'b0;
        if (tick == TICK_LAST) begin
          state_next = DATA;
          tick_next  = 8'd0;
          bit_next   = 3'd0;
          ser_next   = cw_out[6];
        end else begin
          tick_next = tick + 8'd1;
        end
      end
      DATA: begin
        ser_next = cw_out[3'd6 - bitc];
        if (tick == TICK_LAST) begin
          tick_next = 8'd0;
          if (bitc == 3'd6) begin
            state_next = STOP;
            ser_next   = 1'b1;
          end else begin
            bit_next = bitc + 3'd1;
            ser_next = cw_out[3'd5 - bitc];
          end
        end else begin
          tick_next = tick + 8'd1;
        end
      end
      STOP: begin
        if (tick == TICK_LAST) begin
          state_next = IDLE;
          tick_next  = 8'd0;
        end else begin
          tick_next = tick + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick     <= 8'd0;
      bitc     <= 3'd0;
      ser_out  <= 1'b1;
      cw_out   <= 7'd0;
      tx_count <= 8'd0;
    end else begin
      state   <= state_next;
      tick    <= tick_next;
      bitc    <= bit_next;
      ser_out <= ser_next;
      if (state == IDLE && data_valid) begin
        cw_out <= cw_load;
      end
      if (word_done) begin
        tx_count <= tx_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/hamming_tx.md
HAMMING_TX -- requirements
Module: hamming_tx

Interface
REQ-001 The block SHALL have parameter BIT_TICKS, default 4: clock cycles per serial bit, legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port data_in, input, 4 bits: data nibble d[3:0] to encode.
REQ-005 The block SHALL have port data_valid, input, 1 bit: data_in is valid.
REQ-006 The block SHALL have port data_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-007 The block SHALL have port ser_out, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-009 The block SHALL have port word_done, output, 1 bit: one-cycle pulse on the last cycle of the stop bit.
REQ-010 The block SHALL have port cw_out, output, 7 bits: codeword of the current or most recent frame, registered.
REQ-011 The block SHALL have port tx_count, output, 8 bits: count of completed frames.

Function
REQ-012 Codeword c[6:0] SHALL be: c6=d3, c5=d2, c4=d1, c3=d1^d2^d3, c2=d0, c1=d0^d2^d3, c0=d0^d1^d3 (e.g. 1->0000111, 8->1001011, F->1111111).
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 data_ready SHALL be 1 only in IDLE and SHALL be 0 while rst is high.
REQ-015 Acceptance SHALL occur on the edge where data_valid and data_ready are both 1: codeword registered into cw_out, state goes to START.
REQ-016 Data offered when data_ready is 0 SHALL be ignored, not queued.
REQ-017 START SHALL drive ser_out=0 for BIT_TICKS cycles.
REQ-018 DATA SHALL drive c6 first down to c0, each bit for BIT_TICKS cycles.
REQ-019 STOP SHALL drive ser_out=1 for BIT_TICKS cycles, then go to IDLE.
REQ-020 A frame SHALL last exactly 9*BIT_TICKS cycles; with data_valid held high, back-to-back accepts SHALL be 9*BIT_TICKS+1 cycles apart (one IDLE cycle).
REQ-021 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-022 ser_out SHALL be a register output, glitch-free, and 1 in IDLE.
REQ-023 Per frame, word_done SHALL pulse high for exactly 1 cycle, coincident with the last STOP cycle.
REQ-024 tx_count SHALL increment on the same edge that ends STOP, and SHALL wrap 255->0.
REQ-025 For BIT_TICKS=1, every state SHALL last 1 cycle per bit with no skipped or repeated bits.
REQ-026 cw_out SHALL hold its value until the next acceptance.

Reset
REQ-027 Asserting rst at any time, including mid-frame, SHALL immediately force: state IDLE, ser_out=1, busy=0, word_done=0, cw_out=0, tx_count=0, bit and tick counters=0.
REQ-028 A frame aborted by reset SHALL NOT be counted and SHALL NOT resume.
REQ-029 Acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-030 With macro HAM_TX_FAULT_INJECT_EN defined, the block SHALL add input fault_en (1 bit) and input fault_pos (3 bits).
REQ-031 With HAM_TX_FAULT_INJECT_EN defined, fault_en and fault_pos SHALL be sampled at acceptance.
REQ-032 If fault_en=1 and fault_pos is 0..6 at acceptance, the block SHALL invert c[fault_pos] in both cw_out and the transmitted bits.
REQ-033 If fault_pos=7 at acceptance, the block SHALL inject no fault.
REQ-034 Without HAM_TX_FAULT_INJECT_EN, the fault ports SHALL be absent and the codeword SHALL always be as defined in REQ-012.

Verification
REQ-035 The bench SHALL cover: BIT_TICKS=4, data_in=5 accepted -> cw_out=0101101; ser_out = 0 x4, then 0,1,0,1,1,0,1 each x4, then 1 x4; word_done pulses at cycle 36 after accept.
REQ-036 The bench SHALL cover: all 16 nibbles sent -> cw_out matches REQ-012 (0->0000000 ... F->1111111); a receiving decoder returns the original nibble.
REQ-037 The bench SHALL cover: data_valid held high with 0 then F -> accepts exactly 37 cycles apart; busy low for exactly 1 cycle between frames.
REQ-038 The bench SHALL cover: rst pulsed during DATA bit 3 -> ser_out=1 and busy=0 with no clock edge; tx_count unchanged at 0; the next frame is sent correctly.
REQ-039 The bench SHALL cover: 256 frames sent -> tx_count returns to 0; exactly 256 word_done pulses.
REQ-040 The bench SHALL cover: with HAM_TX_FAULT_INJECT_EN, data 0, fault_en=1, fault_pos=3 -> cw_out=0001000; with fault_pos=7 -> 0000000.
